// File: rtl/serial_pkg.sv
// serial_pkg: shared state encoding, line levels and sizing helper for serial_tx (SERIAL_TX_PARITY_EN adds PARITY)
package serial_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bit_timer.sv
// bit_timer: counts 0..CLKS_PER_BIT-1 while enabled and pulses tc on the last cycle of each bit
module bit_timer
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clock,
  input  logic clear,
  input  logic en,
  output logic tc
);
  localparam int CW = idx_w(CLKS_PER_BIT);
  logic [CW-1:0] cnt;
  assign tc = en && cnt == CW'(CLKS_PER_BIT - 1);
  // bit-time counter, wraps on terminal count, held at zero while cleared
  always_ff @(posedge clock) begin
    if (clear) cnt <= '0;
    else if (en) cnt <= tc ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/serial_tx.sv
// serial_tx: LSB-first serial transmitter with start/stop framing; SERIAL_TX_PARITY_EN adds an even-parity bit
module serial_tx
  import serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);
  localparam int IW = idx_w(DATA_W);
  state_t            state;
  logic [DATA_W-1:0] sh;
  logic [IW-1:0]     idx;
  logic              tc;
`ifdef SERIAL_TX_PARITY_EN
  logic              par;
`endif
  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clock(clock),
    .clear(reset || state == IDLE),
    .en   (state != IDLE),
    .tc   (tc)
  );
  // frame sequencer; every output is a register so nothing from the inputs reaches the pins combinationally
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      tx    <= LINE_IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      sh    <= '0;
      idx   <= '0;
`ifdef SERIAL_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (load) begin
          state <= START;
          tx    <= START_BIT;
          ready <= 1'b0;
          busy  <= 1'b1;
          sh    <= data_in;
          idx   <= '0;
`ifdef SERIAL_TX_PARITY_EN
          par   <= ^data_in;
`endif
        end
        START: if (tc) begin
          state <= DATA;
          tx    <= sh[0];
          sh    <= sh >> 1;
        end
        DATA: if (tc) begin
          if (idx == IW'(DATA_W - 1)) begin
`ifdef SERIAL_TX_PARITY_EN
            state <= PARITY;
            tx    <= par;
`else
            state <= STOP;
            tx    <= LINE_IDLE;
`endif
          end else begin
            idx <= idx + 1'b1;
            tx  <= sh[0];
            sh  <= sh >> 1;
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        PARITY: if (tc) begin
          state <= STOP;
          tx    <= LINE_IDLE;
        end
`endif
        STOP: if (tc) begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed and randomized self-checking bench for serial_tx against a frame-level model
`timescale 1ns/1ps
module tb_serial_tx;
  localparam int DW = 8;
  localparam int C  = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NB = DW + 3;
  localparam logic [15:0] EXP_A5 = 16'h054A;
  localparam logic [15:0] EXP_3C = 16'h0478;
  localparam logic [15:0] EXP_07 = 16'h060E;
  localparam logic [15:0] EXP_81 = 16'h0502;
  localparam int EXP_LEN = 44;
`else
  localparam int NB = DW + 2;
  localparam logic [15:0] EXP_A5 = 16'h034A;
  localparam logic [15:0] EXP_3C = 16'h0278;
  localparam logic [15:0] EXP_07 = 16'h020E;
  localparam logic [15:0] EXP_81 = 16'h0302;
  localparam int EXP_LEN = 40;
`endif
  localparam int FL = NB * C;

  logic clock = 1'b0, reset = 1'b1, load = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic ready, tx, busy, done;
  int checks = 0, errors = 0;

  serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(C)) dut (
    .clock(clock), .reset(reset), .load(load), .data_in(data_in),
    .ready(ready), .tx(tx), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // k-th bit of a frame: start, payload LSB first, optional parity, stop
  function automatic logic frame_bit(input logic [DW-1:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= DW) return d[k-1];
`ifdef SERIAL_TX_PARITY_EN
    if (k == DW + 1) return ^d;
`endif
    return 1'b1;
  endfunction

  // model: a frame is accepted when idle, lasts FL cycles, then one done cycle
  logic m_active = 1'b0, m_done = 1'b0;
  int m_age = 0;
  logic [DW-1:0] m_data = '0;
  always @(posedge clock) begin
    if (reset) begin
      m_active = 1'b0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_active) begin
        m_age++;
        if (m_age == FL) begin
          m_active = 1'b0;
          m_done = 1'b1;
        end
      end else if (load) begin
        m_active = 1'b1;
        m_age = 0;
        m_data = data_in;
      end
    end
  end

  always @(negedge clock) begin
    check("tx", tx, m_active ? frame_bit(m_data, m_age / C) : 1'b1);
    check("ready", ready, !m_active);
    check("busy", busy, m_active);
    check("done", done, m_done);
  end

  // starts and ends at a negedge; samples each bit mid-period, returns cycles from acceptance to done
  task automatic run_frame(input logic [DW-1:0] d, input int poke_at, input logic [DW-1:0] poke,
                           output logic [15:0] bits, output int dcyc, output logic first_tx);
    bits = '0;
    dcyc = -1;
    first_tx = 1'bx;
    check("ready_at_load", ready, 1'b1);
    load = 1'b1;
    data_in = d;
    for (int n = 1; n <= FL + 8 && dcyc < 0; n++) begin
      @(negedge clock);
      load = (n == poke_at);
      if (n == poke_at) data_in = poke;
      if (n == 1) first_tx = tx;
      if ((n - 1) % C == C / 2 && (n - 1) / C < 16) bits[(n-1)/C] = tx;
      if (done) dcyc = n - 1;
    end
    load = 1'b0;
  endtask

  logic [15:0] bits;
  int dcyc;
  logic ftx;

  initial begin
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("rst_tx", tx, 1'b1);
      check("rst_ready", ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
    end
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("idle_tx", tx, 1'b1);

    run_frame(8'hA5, 0, '0, bits, dcyc, ftx);
    check("a5_bits", bits, EXP_A5);
    check("a5_len", dcyc, EXP_LEN);
    repeat (2) @(negedge clock);

    run_frame(8'h3C, 10, 8'hFF, bits, dcyc, ftx);
    check("3c_bits", bits, EXP_3C);
    check("3c_len", dcyc, EXP_LEN);
    repeat (2) @(negedge clock);

    run_frame(8'h07, 0, '0, bits, dcyc, ftx);
    check("07_bits", bits, EXP_07);
    check("07_len", dcyc, EXP_LEN);
    check("b2b_done", done, 1'b1);
    run_frame(8'h81, 0, '0, bits, dcyc, ftx);
    check("b2b_first_tx", ftx, 1'b0);
    check("81_bits", bits, EXP_81);
    check("81_len", dcyc, EXP_LEN);
    repeat (2) @(negedge clock);

    load = 1'b1;
    data_in = 8'h5A;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clock);
      load = 1'b0;
    end
    @(negedge clock);
    reset = 1'b1;
    load = 1'b1;
    data_in = 8'hFF;
    @(negedge clock);
    reset = 1'b0;
    load = 1'b0;
    check("abort_tx", tx, 1'b1);
    check("abort_ready", ready, 1'b1);
    check("abort_done", done, 1'b0);
    for (int i = 0; i < FL + 4; i++) begin
      @(negedge clock);
      check("abort_no_done", done, 1'b0);
      check("abort_idle", busy, 1'b0);
    end

    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      reset = $urandom_range(0, 199) == 0;
      load = $urandom_range(0, 3) == 0;
      data_in = DW'($urandom);
    end
    reset = 1'b0;
    load = 1'b0;
    repeat (FL + 4) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
